// File: rtl/fifo_leitor.sv
// rtl/fifo_leitor.sv - read-side drain controller: FIFO pops to a valid/ready stream via a credit-checked buffer
// Define FIFO_LEITOR_CNT_EN to add the palavras_lidas delivered-word counter port.
module fifo_leitor #(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             habilitar,
    input  logic             fila_vazia,
    output logic             ler_data,
    input  logic [WIDTH-1:0] data_ent,
    output logic [WIDTH-1:0] data_sai,
    output logic             sai_valido,
    input  logic             sai_pronto,
`ifdef FIFO_LEITOR_CNT_EN
    output logic [CNT_W-1:0] palavras_lidas,
`endif
    output logic             ocupado
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W:0] DEPTH_C = (OCC_W + 1)'(DEPTH);

    if (RD_LAT < 1 || RD_LAT > 2 || CNT_W < 1 || WIDTH < 1) begin : g_param_err
        $error("fifo_leitor: illegal parameter value");
    end

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        DRENANDO   = 2'd1,
        ESVAZIANDO = 2'd2
    } estado_t;

    estado_t           state_q, state_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d, inflight;
    logic [OCC_W:0]    credito;
    logic              captura, transfere;

    function automatic logic [PTR_W-1:0] avanca(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OCC_W'(pipe_q[i]);
        end
    end

    // Credit counts both buffered words and reads still in the FIFO pipeline,
    // so a capture always finds a free slot without looking at sai_pronto.
    assign credito    = {1'b0, occ_q} + {1'b0, inflight};
    assign captura    = pipe_q[RD_LAT-1];
    assign sai_valido = (occ_q != '0);
    assign transfere  = sai_valido & sai_pronto;
    assign data_sai   = sai_valido ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= OCIOSO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OCIOSO:     if (habilitar) state_d = DRENANDO;
            DRENANDO:   if (!habilitar) state_d = ESVAZIANDO;
            ESVAZIANDO: if (inflight == '0 && occ_q == '0) state_d = OCIOSO;
            default:    state_d = OCIOSO;
        endcase
    end

    always_comb begin
        ocupado  = (state_q != OCIOSO);
        ler_data = rst && (state_q == DRENANDO) && !fila_vazia && (credito < DEPTH_C);
    end

    always_comb begin
        pipe_d   = (pipe_q << 1) | RD_LAT'(ler_data);
        rd_ptr_d = transfere ? avanca(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = captura ? avanca(wr_ptr_q) : wr_ptr_q;
        occ_d    = occ_q;
        if (captura && !transfere) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!captura && transfere) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            pipe_q   <= pipe_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: data_sai is gated by sai_valido.
    always_ff @(posedge clk) begin
        if (captura) begin
            mem_q[wr_ptr_q] <= data_ent;
        end
    end

`ifdef FIFO_LEITOR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = transfere ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign palavras_lidas = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_leitor.sv
// tb/tb_fifo_leitor.sv - bench for fifo_leitor: RD_LAT=1 and RD_LAT=2 lanes against a word-accounting model
module tb_fifo_leitor;
    localparam int W     = 8;
    localparam int CNT_W = 16;
    localparam int NL    = 2;
    localparam int MAXW  = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic habilitar = 1'b0;
    logic sai_pronto = 1'b0;
    logic [NL-1:0] fila_vazia, ler_data, sai_valido, ocupado;
    logic [W-1:0] data_ent [NL];
    logic [W-1:0] data_sai [NL];
`ifdef FIFO_LEITOR_CNT_EN
    logic [CNT_W-1:0] palavras_lidas [NL];
    logic [CNT_W-1:0] cnt_exp [NL] = '{default: '0};
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_leitor #(.WIDTH(W), .RD_LAT(1), .CNT_W(CNT_W)) u_lat1 (
        .clk(clk), .rst(rst), .habilitar(habilitar), .fila_vazia(fila_vazia[0]),
        .ler_data(ler_data[0]), .data_ent(data_ent[0]), .data_sai(data_sai[0]),
        .sai_valido(sai_valido[0]), .sai_pronto(sai_pronto),
`ifdef FIFO_LEITOR_CNT_EN
        .palavras_lidas(palavras_lidas[0]),
`endif
        .ocupado(ocupado[0]));

    fifo_leitor #(.WIDTH(W), .RD_LAT(2), .CNT_W(CNT_W)) u_lat2 (
        .clk(clk), .rst(rst), .habilitar(habilitar), .fila_vazia(fila_vazia[1]),
        .ler_data(ler_data[1]), .data_ent(data_ent[1]), .data_sai(data_sai[1]),
        .sai_valido(sai_valido[1]), .sai_pronto(sai_pronto),
`ifdef FIFO_LEITOR_CNT_EN
        .palavras_lidas(palavras_lidas[1]),
`endif
        .ocupado(ocupado[1]));

    // Source FIFO: same contents for both lanes, each lane with its own read index and latency.
    logic [W-1:0] src [MAXW];
    int wr_idx = 0;
    int rd_idx [NL] = '{default: 0};
    logic [W-1:0] lat_a [NL];
    logic [W-1:0] lat_b [NL];

    always_comb begin
        for (int l = 0; l < NL; l++) begin
            fila_vazia[l] = (rd_idx[l] >= wr_idx);
            data_ent[l]   = (l == 0) ? lat_a[l] : lat_b[l];
        end
    end

    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (ler_data[l] && rd_idx[l] < wr_idx) begin
                lat_a[l]  <= src[rd_idx[l]];
                rd_idx[l] <= rd_idx[l] + 1;
            end else begin
                lat_a[l] <= 8'hEE;
            end
            lat_b[l] <= lat_a[l];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] v);
        src[wr_idx] = v;
        wr_idx++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: words are counted as popped, landed (visible RD_LAT+1 cycles after the pop) and delivered.
    int cyc = 0;
    int pops   [NL] = '{default: 0};
    int landed [NL] = '{default: 0};
    int deliv  [NL] = '{default: 0};
    int st     [NL] = '{default: 0};
    int ntx    [NL] = '{default: 0};
    int pop_cyc [NL][MAXW];
    int tx_cyc  [NL][MAXW];
    logic [W-1:0] tx_log [NL][MAXW];

    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            int lat, depth, occ, infl;
            logic exp_ler, xfer;
            lat   = l + 1;
            depth = lat + 2;
            while (landed[l] < pops[l] && pop_cyc[l][landed[l]] + lat + 1 <= cyc) landed[l]++;
            occ     = landed[l] - deliv[l];
            infl    = pops[l] - landed[l];
            exp_ler = rst && st[l] == 1 && !fila_vazia[l] && (pops[l] - deliv[l]) < depth;
            chk($sformatf("ler_data lane%0d cyc%0d", l, cyc), 32'(ler_data[l]), 32'(exp_ler));
            chk($sformatf("sai_valido lane%0d cyc%0d", l, cyc), 32'(sai_valido[l]), 32'(occ > 0));
            if (occ > 0)
                chk($sformatf("data_sai lane%0d cyc%0d", l, cyc), 32'(data_sai[l]), 32'(src[deliv[l]]));
            chk($sformatf("ocupado lane%0d cyc%0d", l, cyc), 32'(ocupado[l]), 32'(st[l] != 0));
            chk($sformatf("occ_bound lane%0d cyc%0d", l, cyc), 32'(pops[l] - deliv[l] <= depth), 32'd1);
`ifdef FIFO_LEITOR_CNT_EN
            chk($sformatf("palavras_lidas lane%0d cyc%0d", l, cyc), 32'(palavras_lidas[l]), 32'(cnt_exp[l]));
`endif
            xfer = rst && occ > 0 && sai_pronto;
            if (!rst) begin
                landed[l] = pops[l];
                deliv[l]  = pops[l];
                st[l]     = 0;
`ifdef FIFO_LEITOR_CNT_EN
                cnt_exp[l] = '0;
`endif
            end else begin
                if (xfer) begin
                    tx_log[l][ntx[l]] = data_sai[l];
                    tx_cyc[l][ntx[l]] = cyc;
                    ntx[l]++;
                    deliv[l]++;
`ifdef FIFO_LEITOR_CNT_EN
                    cnt_exp[l] = cnt_exp[l] + 1'b1;
`endif
                end
                if (ler_data[l]) begin
                    pop_cyc[l][pops[l]] = cyc;
                    pops[l]++;
                end
                case (st[l])
                    0: if (habilitar) st[l] = 1;
                    1: if (!habilitar) st[l] = 2;
                    default: if (infl == 0 && occ == 0) st[l] = 0;
                endcase
            end
        end
        cyc++;
    end

    initial begin
        int bp [NL];
        int bt [NL];
        int bad;

        // Reset held 2 cycles with a non-empty FIFO, habilitar=1 and a ready sink.
        habilitar  = 1'b1;
        sai_pronto = 1'b1;
        for (int i = 1; i <= 9; i++) push(8'(i));
        tick(2);
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("reset ler_data lane%0d", l), 32'(ler_data[l]), 32'd0);
            chk($sformatf("reset sai_valido lane%0d", l), 32'(sai_valido[l]), 32'd0);
            chk($sformatf("reset ocupado lane%0d", l), 32'(ocupado[l]), 32'd0);
            bp[l] = pops[l];
            bt[l] = ntx[l];
        end

        // Streaming 1..9 at one word per cycle.
        rst = 1'b1;
        for (int i = 0; i < 60 && !(ntx[0] - bt[0] >= 9 && ntx[1] - bt[1] >= 9); i++) tick(1);
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("stream done lane%0d", l), 32'(ntx[l] - bt[l]), 32'd9);
            chk($sformatf("stream pops lane%0d", l), 32'(pops[l] - bp[l]), 32'd9);
            chk($sformatf("stream first latency lane%0d", l), 32'(tx_cyc[l][bt[l]] - pop_cyc[l][bp[l]]), 32'(l + 2));
            bad = 0;
            for (int k = 0; k < 9; k++) begin
                if (tx_log[l][bt[l] + k] != 8'(k + 1)) bad++;
                if (tx_cyc[l][bt[l] + k] != tx_cyc[l][bt[l]] + k) bad++;
            end
            chk($sformatf("stream order lane%0d", l), 32'(bad), 32'd0);
        end

        // Backpressure: sink stalls 5 cycles mid-stream.
        for (int l = 0; l < NL; l++) bt[l] = ntx[l];
        for (int i = 0; i < 10; i++) push(8'h20 + 8'(i));
        tick(3);
        sai_pronto = 1'b0;
        tick(5);
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("stall outstanding lane%0d", l), 32'(pops[l] - ntx[l]), 32'(l + 3));
            chk($sformatf("stall valid lane%0d", l), 32'(sai_valido[l]), 32'd1);
        end
        sai_pronto = 1'b1;
        for (int i = 0; i < 60 && !(ntx[0] - bt[0] >= 10 && ntx[1] - bt[1] >= 10); i++) tick(1);
        for (int l = 0; l < NL; l++) begin
            bad = 0;
            for (int k = 0; k < 10; k++) if (tx_log[l][bt[l] + k] != 8'h20 + 8'(k)) bad++;
            chk($sformatf("bp done lane%0d", l), 32'(ntx[l] - bt[l]), 32'd10);
            chk($sformatf("bp order lane%0d", l), 32'(bad), 32'd0);
        end

        // Random sink readiness, 20 words.
        for (int l = 0; l < NL; l++) bt[l] = ntx[l];
        for (int i = 0; i < 20; i++) push(8'h40 + 8'(i));
        for (int i = 0; i < 400 && !(ntx[0] - bt[0] >= 20 && ntx[1] - bt[1] >= 20); i++) begin
            sai_pronto = 1'($urandom_range(0, 1));
            tick(1);
        end
        sai_pronto = 1'b1;
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("random done lane%0d", l), 32'(ntx[l] - bt[l]), 32'd20);
            chk($sformatf("random last word lane%0d", l), 32'(tx_log[l][bt[l] + 19]), 32'h53);
        end
        tick(2);

        // Stop: habilitar drops with two reads issued; both words still delivered.
        for (int l = 0; l < NL; l++) begin
            bp[l] = pops[l];
            bt[l] = ntx[l];
        end
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        tick(1);
        habilitar = 1'b0;
        for (int i = 0; i < 40 && (ocupado != '0 || cyc < 0); i++) tick(1);
        chk("stop idle", 32'(ocupado), 32'd0);
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("stop pops lane%0d", l), 32'(pops[l] - bp[l]), 32'd2);
            chk($sformatf("stop delivered lane%0d", l), 32'(ntx[l] - bt[l]), 32'd2);
            chk($sformatf("stop second word lane%0d", l), 32'(tx_log[l][bt[l] + 1]), 32'h61);
            chk($sformatf("stop ocupado after last xfer lane%0d", l), 32'(tx_cyc[l][bt[l] + 1] < cyc - 1), 32'd1);
        end

        // Reset mid-burst with a full buffer.
        sai_pronto = 1'b0;
        habilitar  = 1'b1;
        for (int i = 0; i < 10; i++) push(8'h80 + 8'(i));
        tick(8);
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("burst buffered lane%0d", l), 32'(pops[l] - ntx[l]), 32'(l + 3));
            chk($sformatf("burst head lane%0d", l), 32'(data_sai[l]), 32'h62);
        end
        rst = 1'b0;
        tick(1);
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("midreset sai_valido lane%0d", l), 32'(sai_valido[l]), 32'd0);
            chk($sformatf("midreset ocupado lane%0d", l), 32'(ocupado[l]), 32'd0);
`ifdef FIFO_LEITOR_CNT_EN
            chk($sformatf("midreset palavras_lidas lane%0d", l), 32'(palavras_lidas[l]), 32'd0);
`endif
        end
        rst = 1'b1;
        sai_pronto = 1'b1;
        bt[0] = ntx[0];
        for (int i = 0; i < 40 && ntx[0] - bt[0] < 5; i++) tick(1);
        chk("post-reset transfers", 32'(ntx[0] - bt[0]), 32'd5);
`ifdef FIFO_LEITOR_CNT_EN
        chk("palavras_lidas after 5", 32'(palavras_lidas[0]), 32'd5);
`endif

        habilitar = 1'b0;
        for (int i = 0; i < 60 && ocupado != '0; i++) tick(1);
        chk("final idle", 32'(ocupado), 32'd0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
